// File: rtl/fprint_compare_ctrl.sv
// Round-robin scheduler that walks two redundant CRC fingerprint buffers in lockstep
// and reports a pass/fail result per task to both replicas and the monitor.
module fprint_compare_ctrl #(
    parameter int KEY_WIDTH  = 4,
    parameter int KEY_SIZE   = 16,
    parameter int CRC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [KEY_SIZE-1:0]   fprints_ready_a,
    input  logic [KEY_SIZE-1:0]   fprints_ready_b,
    input  logic [ADDR_WIDTH-1:0] head_a,
    input  logic [ADDR_WIDTH-1:0] tail_a,
    input  logic [ADDR_WIDTH-1:0] head_b,
    input  logic [ADDR_WIDTH-1:0] tail_b,
    input  logic [CRC_WIDTH-1:0]  crc_a,
    input  logic [CRC_WIDTH-1:0]  crc_b,
    input  logic                  comp_w_ack_a,
    input  logic                  comp_w_ack_b,
    output logic [KEY_WIDTH-1:0]  comparator_current_task,
    output logic                  comparator_increment_ram_address,
    output logic                  comparator_register_write,
    output logic                  comparator_collision_detected,
    output logic                  fprints_checked,
    output logic                  status_valid,
    output logic [KEY_WIDTH-1:0]  status_task,
    output logic                  status_fail,
    output logic [7:0]            fail_count,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, LOAD, LEN, READ, COMPARE, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [KEY_WIDTH-1:0]  last, pick, idx;
    logic                  pick_vld;
    logic [KEY_SIZE-1:0]   cand;
    logic [ADDR_WIDTH-1:0] cnt, len_a, len_b;
    logic                  fail, ack_a_seen, ack_b_seen, ack_a_nxt, ack_b_nxt, both_acked, crc_eq;

    assign cand       = fprints_ready_a & fprints_ready_b;
    assign len_a      = tail_a - head_a;
    assign len_b      = tail_b - head_b;
    assign crc_eq     = (crc_a == crc_b);
    assign ack_a_nxt  = ack_a_seen | comp_w_ack_a;
    assign ack_b_nxt  = ack_b_seen | comp_w_ack_b;
    assign both_acked = ack_a_nxt & ack_b_nxt;

    // Scan offsets from far to near so the nearest candidate after last wins;
    // offset KEY_SIZE truncates to last itself, the lowest priority.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = KEY_SIZE; i >= 1; i--) begin
            idx = last + i[KEY_WIDTH-1:0];
            if (cand[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && pick_vld) state_nxt = LOAD;
            LOAD:    state_nxt = LEN;
            LEN:     state_nxt = (len_a != len_b || len_a == '0) ? WRITE : READ;
            READ:    state_nxt = COMPARE;
            COMPARE: state_nxt = (!crc_eq || cnt == ADDR_WIDTH'(1)) ? WRITE : READ;
            WRITE:   if (both_acked) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        comparator_increment_ram_address = (state == COMPARE) && crc_eq;
        comparator_register_write        = (state == WRITE);
        comparator_collision_detected    = (state == WRITE) && fail;
        status_valid                     = (state == DONE);
        fprints_checked                  = (state == DONE) && !fail;
        busy                             = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last                    <= KEY_WIDTH'(KEY_SIZE - 1);
            comparator_current_task <= '0;
            cnt                     <= '0;
            fail                    <= 1'b0;
            ack_a_seen              <= 1'b0;
            ack_b_seen              <= 1'b0;
            status_task             <= '0;
            status_fail             <= 1'b0;
            fail_count              <= '0;
        end else begin
            case (state)
                IDLE: if (enable && pick_vld) begin
                    comparator_current_task <= pick;
                    last                    <= pick;
                end
                LEN: begin
                    fail <= (len_a != len_b);
                    cnt  <= len_a;
                end
                COMPARE: begin
                    if (!crc_eq) fail <= 1'b1;
                    else         cnt  <= cnt - ADDR_WIDTH'(1);
                end
                WRITE: begin
                    ack_a_seen <= ack_a_nxt;
                    ack_b_seen <= ack_b_nxt;
                    // Result registers update on the way into DONE so they are visible with the strobe.
                    if (both_acked) begin
                        status_task <= comparator_current_task;
                        status_fail <= fail;
                        if (fail && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                    end
                end
                DONE: begin
                    ack_a_seen <= 1'b0;
                    ack_b_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fprint_compare_ctrl.sv
// Directed bench: two modelled CRC RAMs, manual or automatic acks, per-feature test tasks.
module tb_fprint_compare_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] fprints_ready_a, fprints_ready_b;
    logic [5:0]  head_a, tail_a, head_b, tail_b;
    logic [31:0] crc_a, crc_b;
    logic        comp_w_ack_a, comp_w_ack_b;
    logic [3:0]  comparator_current_task;
    logic        comparator_increment_ram_address, comparator_register_write;
    logic        comparator_collision_detected, fprints_checked, status_valid;
    logic [3:0]  status_task;
    logic        status_fail;
    logic [7:0]  fail_count;
    logic        busy;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int          inc_cnt;
    logic        clr_inc, auto_ack, man_ack_a, man_ack_b;
    logic [5:0]  ra_a, ra_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fprint_compare_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fprints_ready_a(fprints_ready_a), .fprints_ready_b(fprints_ready_b),
        .head_a(head_a), .tail_a(tail_a), .head_b(head_b), .tail_b(tail_b),
        .crc_a(crc_a), .crc_b(crc_b),
        .comp_w_ack_a(comp_w_ack_a), .comp_w_ack_b(comp_w_ack_b),
        .comparator_current_task(comparator_current_task),
        .comparator_increment_ram_address(comparator_increment_ram_address),
        .comparator_register_write(comparator_register_write),
        .comparator_collision_detected(comparator_collision_detected),
        .fprints_checked(fprints_checked), .status_valid(status_valid),
        .status_task(status_task), .status_fail(status_fail),
        .fail_count(fail_count), .busy(busy)
    );

    // Replica RAM model: read pointer = head + number of increments seen.
    always @(posedge clk)
        if (clr_inc) inc_cnt <= 0;
        else if (comparator_increment_ram_address) inc_cnt <= inc_cnt + 1;

    assign ra_a  = head_a + inc_cnt[5:0];
    assign ra_b  = head_b + inc_cnt[5:0];
    assign crc_a = mem_a[ra_a];
    assign crc_b = mem_b[ra_b];
    assign comp_w_ack_a = man_ack_a | (auto_ack & comparator_register_write);
    assign comp_w_ack_b = man_ack_b | (auto_ack & comparator_register_write);

    task automatic setup(input logic [15:0] rdy, input logic [5:0] ha, ta, hb, tb);
        fprints_ready_a = rdy; fprints_ready_b = rdy;
        head_a = ha; tail_a = ta; head_b = hb; tail_b = tb;
    endtask

    // Leaves the bench at the negedge where the DUT sits in LOAD.
    task automatic kick();
        @(negedge clk);
        enable = 1'b1; clr_inc = 1'b1;
        @(negedge clk);
        enable = 1'b0; clr_inc = 1'b0;
        fprints_ready_a = '0; fprints_ready_b = '0;
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (comparator_register_write) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (status_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit quiet;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, comparator_current_task, comparator_register_write, status_valid, fprints_checked,
             status_task, status_fail, fail_count} !== '0) begin
            errors++; $display("FAIL reset_state busy=%0b task=%0d fc=%0d", busy, comparator_current_task, fail_count);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin mem_a[i] = 32'hA0 + i; mem_b[i] = 32'hA0 + i; end
        setup(16'h0008, 0, 4, 0, 4);
        kick();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (comparator_increment_ram_address) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || comparator_current_task !== 4'd3) begin
            errors++; $display("FAIL reach_compare got_inc=%0b task=%0d want 1/3", ok, comparator_current_task);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, comparator_current_task, comparator_increment_ram_address, comparator_register_write,
             comparator_collision_detected, status_valid, fprints_checked, status_task, status_fail, fail_count} !== '0) begin
            errors++; $display("FAIL mid_reset busy=%0b task=%0d inc=%0b fc=%0d want all 0", busy,
                               comparator_current_task, comparator_increment_ram_address, fail_count);
        end
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (status_valid || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL post_reset_quiet got activity want none"); end
        // last must be back at 15, so task 0 beats task 15
        auto_ack = 1'b1;
        setup(16'h8001, 0, 0, 0, 0);
        kick();
        checks++;
        if (comparator_current_task !== 4'd0) begin
            errors++; $display("FAIL rr_after_reset task=%0d want 0", comparator_current_task);
        end
        wait_done(ok);
        auto_ack = 1'b0;
    endtask

    task automatic test_pass();
        bit ok;
        bit held;
        mem_a[0] = 32'hDEADBEEF; mem_b[0] = 32'hDEADBEEF;
        mem_a[1] = 32'h1;        mem_b[1] = 32'h1;
        mem_a[2] = 32'h2;        mem_b[2] = 32'h2;
        setup(16'h0020, 0, 3, 0, 3);
        kick();
        checks++;
        if (comparator_current_task !== 4'd5) begin
            errors++; $display("FAIL pass_task task=%0d want 5", comparator_current_task);
        end
        wait_write(ok);
        checks++;
        if (!ok || inc_cnt != 3 || comparator_collision_detected !== 1'b0) begin
            errors++; $display("FAIL pass_write ok=%0b incs=%0d coll=%0b want 1/3/0", ok, inc_cnt, comparator_collision_detected);
        end
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (comparator_register_write !== 1'b1 || status_valid) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL pass_hold write not held without acks"); end
        man_ack_a = 1'b1; man_ack_b = 1'b1;
        @(negedge clk);
        man_ack_a = 1'b0; man_ack_b = 1'b0;
        checks++;
        if (status_valid !== 1'b1 || fprints_checked !== 1'b1 || status_task !== 4'd5 ||
            status_fail !== 1'b0 || comparator_register_write !== 1'b0) begin
            errors++; $display("FAIL pass_done sv=%0b chk=%0b task=%0d sf=%0b wr=%0b want 1/1/5/0/0",
                               status_valid, fprints_checked, status_task, status_fail, comparator_register_write);
        end
        @(negedge clk);
        checks++;
        if (status_valid !== 1'b0 || busy !== 1'b0 || status_task !== 4'd5) begin
            errors++; $display("FAIL pass_after sv=%0b busy=%0b task=%0d want 0/0/5", status_valid, busy, status_task);
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        mem_a[0] = 32'h7;  mem_b[0] = 32'h7;
        mem_a[1] = 32'h10; mem_b[1] = 32'h11;
        mem_a[2] = 32'h5;  mem_b[2] = 32'h5;
        setup(16'h0004, 0, 3, 0, 3);
        kick();
        wait_write(ok);
        checks++;
        if (!ok || inc_cnt != 1 || comparator_collision_detected !== 1'b1 || comparator_current_task !== 4'd2) begin
            errors++; $display("FAIL mism_write ok=%0b incs=%0d coll=%0b task=%0d want 1/1/1/2",
                               ok, inc_cnt, comparator_collision_detected, comparator_current_task);
        end
        man_ack_a = 1'b1; man_ack_b = 1'b1;
        @(negedge clk);
        man_ack_a = 1'b0; man_ack_b = 1'b0;
        checks++;
        if (status_valid !== 1'b1 || fprints_checked !== 1'b0 || status_fail !== 1'b1 ||
            status_task !== 4'd2 || fail_count !== 8'd1) begin
            errors++; $display("FAIL mism_done sv=%0b chk=%0b sf=%0b task=%0d fc=%0d want 1/0/1/2/1",
                               status_valid, fprints_checked, status_fail, status_task, fail_count);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int n;
        logic [3:0] got [2];
        got[0] = 4'hF; got[1] = 4'hF;
        auto_ack = 1'b1;
        setup(16'h0001, 0, 0, 0, 0);
        kick();
        wait_done(ok);
        checks++;
        if (!ok || status_task !== 4'd0) begin
            errors++; $display("FAIL rr_prime ok=%0b task=%0d want 1/0", ok, status_task);
        end
        @(negedge clk);
        setup(16'h0011, 0, 0, 0, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            if (status_valid) begin
                got[n] = status_task;
                n++;
            end
        end
        enable = 1'b0;
        fprints_ready_a = '0; fprints_ready_b = '0;
        checks++;
        if (n != 2 || got[0] !== 4'd4 || got[1] !== 4'd0) begin
            errors++; $display("FAIL rr_order n=%0d first=%0d second=%0d want 2/4/0", n, got[0], got[1]);
        end
        @(negedge clk);
        auto_ack = 1'b0;
    endtask

    task automatic test_len_wrap();
        bit ok;
        auto_ack = 1'b1;
        setup(16'h0080, 0, 4, 0, 3);
        kick();
        wait_write(ok);
        checks++;
        if (!ok || inc_cnt != 0 || comparator_collision_detected !== 1'b1) begin
            errors++; $display("FAIL len_mismatch ok=%0b incs=%0d coll=%0b want 1/0/1", ok, inc_cnt, comparator_collision_detected);
        end
        wait_done(ok);
        checks++;
        if (!ok || status_fail !== 1'b1 || status_task !== 4'd7 || fail_count !== 8'd2) begin
            errors++; $display("FAIL len_done ok=%0b sf=%0b task=%0d fc=%0d want 1/1/7/2", ok, status_fail, status_task, fail_count);
        end
        mem_a[62] = 32'h11; mem_b[62] = 32'h11;
        mem_a[63] = 32'h22; mem_b[63] = 32'h22;
        mem_a[0]  = 32'h33; mem_b[0]  = 32'h33;
        mem_a[1]  = 32'h99; mem_b[1]  = 32'h98;
        setup(16'h0200, 62, 1, 62, 1);
        kick();
        wait_write(ok);
        checks++;
        if (!ok || inc_cnt != 3 || comparator_collision_detected !== 1'b0) begin
            errors++; $display("FAIL wrap_write ok=%0b incs=%0d coll=%0b want 1/3/0", ok, inc_cnt, comparator_collision_detected);
        end
        wait_done(ok);
        checks++;
        if (!ok || status_fail !== 1'b0 || fprints_checked !== 1'b1 || status_task !== 4'd9) begin
            errors++; $display("FAIL wrap_done ok=%0b sf=%0b chk=%0b task=%0d want 1/0/1/9", ok, status_fail, fprints_checked, status_task);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_ack_order();
        bit ok;
        bit held;
        setup(16'h0040, 5, 5, 5, 5);
        kick();
        wait_write(ok);
        man_ack_b = 1'b1;
        @(negedge clk);
        man_ack_b = 1'b0;
        held = ok;
        for (int i = 0; i < 4; i++) begin
            if (comparator_register_write !== 1'b1 || status_valid) held = 1'b0;
            @(negedge clk);
        end
        if (comparator_register_write !== 1'b1) held = 1'b0;
        checks++;
        if (!held) begin errors++; $display("FAIL ack_b_only write dropped before ack_a"); end
        man_ack_a = 1'b1;
        @(negedge clk);
        man_ack_a = 1'b0;
        checks++;
        if (status_valid !== 1'b1 || comparator_register_write !== 1'b0 || status_task !== 4'd6) begin
            errors++; $display("FAIL ack_a_done sv=%0b wr=%0b task=%0d want 1/0/6", status_valid, comparator_register_write, status_task);
        end
    endtask

    task automatic test_saturate();
        int n;
        auto_ack = 1'b1;
        setup(16'h0002, 0, 1, 0, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 3000 && n < 256; i++) begin
            @(negedge clk);
            if (status_valid) begin
                n++;
                if (n == 252) begin
                    checks++;
                    if (fail_count !== 8'd254) begin
                        errors++; $display("FAIL sat_pre fc=%0d want 254", fail_count);
                    end
                end
            end
        end
        enable = 1'b0;
        checks++;
        if (n != 256 || fail_count !== 8'd255 || status_fail !== 1'b1) begin
            errors++; $display("FAIL sat_final n=%0d fc=%0d sf=%0b want 256/255/1", n, fail_count, status_fail);
        end
        auto_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        enable = 1'b0; clr_inc = 1'b1; auto_ack = 1'b0; man_ack_a = 1'b0; man_ack_b = 1'b0;
        setup(16'h0000, 0, 0, 0, 0);
        test_reset();
        test_pass();
        test_mismatch();
        test_round_robin();
        test_len_wrap();
        test_ack_order();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fprint_compare_ctrl.md
Name: fprint_compare_ctrl

Overview:
- Scheduler and sequencer for fingerprint comparison between two redundant cores' CRC state/directory blocks (replica A, replica B).
- Picks a task whose fingerprints are ready in both replicas (round-robin), walks both CRC buffers in lockstep and compares entries.
- Drives the comparator_* inputs of both replicas and reports pass/fail per task.
- Sits between the two replica state-register blocks and the monitor core's interrupt logic.

Parameters:
- KEY_WIDTH, 4, task index width.
- KEY_SIZE, 16, number of tasks (2^KEY_WIDTH).
- CRC_WIDTH, 32, fingerprint word width.
- ADDR_WIDTH, 6, CRC RAM pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scheduling enable; sampled only in IDLE.
- fprints_ready_a  in  KEY_SIZE  per-task ready bits, replica A.
- fprints_ready_b  in  KEY_SIZE  per-task ready bits, replica B.
- head_a, tail_a  in  ADDR_WIDTH  buffer pointers of current_task, replica A.
- head_b, tail_b  in  ADDR_WIDTH  buffer pointers of current_task, replica B.
- crc_a, crc_b  in  CRC_WIDTH  CRC RAM read data.
- comp_w_ack_a, comp_w_ack_b  in  1  register-write acknowledges.
- comparator_current_task  out  KEY_WIDTH  task under comparison, to both replicas.
- comparator_increment_ram_address  out  1  read-pointer advance pulse, to both replicas.
- comparator_register_write  out  1  completion write, held until acknowledged.
- comparator_collision_detected  out  1  mismatch flag, valid with register_write.
- fprints_checked  out  1  one-cycle pass pulse.
- status_valid  out  1  one-cycle result strobe.
- status_task  out  KEY_WIDTH  task of the last result.
- status_fail  out  1  last result failed.
- fail_count  out  8  saturating mismatch count.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM to IDLE. All outputs 0. Round-robin pointer last = KEY_SIZE-1. Entry counter 0.
- Reset is honoured mid-operation: the FSM returns to IDLE and any in-flight comparison is abandoned without a status strobe.
- States: IDLE, LOAD, LEN, READ, COMPARE, WRITE, DONE.
- IDLE:
  - Candidates = fprints_ready_a & fprints_ready_b.
  - If enable and candidates != 0: select the first set bit scanning last+1, last+2, … with modulo-KEY_SIZE wrap.
  - Register the selection into comparator_current_task and last. Go to LOAD.
- LOAD: one cycle for the directory pointers to settle. Go to LEN.
- LEN:
  - len_a = tail_a - head_a mod 2^ADDR_WIDTH; len_b likewise.
  - If len_a != len_b: fail=1, go to WRITE.
  - Else if len_a == 0: fail=0, go to WRITE.
  - Else load counter = len_a, go to READ.
- READ: one wait cycle for RAM read latency. Go to COMPARE.
- COMPARE:
  - If crc_a != crc_b: fail=1, go to WRITE.
  - Else pulse comparator_increment_ram_address for this cycle and decrement counter.
  - If the counter was 1: fail=0, go to WRITE. Otherwise go to READ.
  - Throughput is 2 cycles per entry.
  - No increment is issued on the mismatching cycle.
- WRITE:
  - comparator_register_write=1 and comparator_collision_detected=fail, both held.
  - Track each ack in a sticky flag; the two acks may arrive in any order or together.
  - When both flags are set: deassert both outputs, go to DONE.
- DONE (1 cycle):
  - status_valid=1. status_task and status_fail are updated and held until the next DONE.
  - fprints_checked=1 iff not fail.
  - If fail, fail_count increments, saturating at 255.
  - Go to IDLE.
- comparator_current_task is stable from LOAD through DONE.
- Ready bits are ignored outside IDLE. A bit dropping mid-comparison does not abort the comparison.
- Deasserting enable mid-comparison has no effect until the next return to IDLE.
- Pointer wrap: tail < head is a valid wrapped buffer (e.g. head=60, tail=2, ADDR_WIDTH=6 gives length 6).

Test Plan:
- Reset mid-COMPARE (task 3, 4 entries) → next cycle busy=0, all outputs 0. No status_valid. fail_count unchanged.
- Task 5 ready in both replicas, 3 identical CRCs (0xDEADBEEF, 0x1, 0x2), head=0, tail=3 in both → exactly 3 increment pulses. register_write with collision=0 until both acks. Then fprints_checked=1, status_valid, status_task=5, status_fail=0.
- Task 2, second CRC differs (0x10 vs 0x11) → 1 increment pulse, then register_write with collision=1. status_fail=1, fail_count=1, no fprints_checked.
- Ready_a=ready_b=0x0011, last=0 → task 4 served first, then task 0. With only task 0 ready after last=4, the scan wraps to 0.
- Length mismatch (len_a=4, len_b=3) and wrapped pointers (head=62, tail=1 both → length 3) → first fails with zero increments; second passes with 3 increments.
- ack_b arrives 5 cycles before ack_a → register_write held until ack_a. DONE follows on the next cycle.
- 256 forced mismatches → fail_count saturates at 255.
